// File: rtl/watch_pkg.sv
// Shared constants, state encoding and display helper
// for the watch time-set controller slice.
package watch_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int DISP_W = 14;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;
  localparam logic [1:0] ST_COMMIT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    SET_HOUR = ST_SET_HOUR,
    SET_MIN  = ST_SET_MIN,
    COMMIT   = ST_COMMIT
  } state_t;

  // HH:MM packed as hour*100+minute in plain binary
  function automatic logic [DISP_W-1:0] disp_word(
    input logic [HOUR_W-1:0] h,
    input logic [MIN_W-1:0]  m
  );
    return DISP_W'(h) * DISP_W'(100) + DISP_W'(m);
  endfunction

endpackage

// File: rtl/wrap_updown_counter.sv
// Loadable up/down counter wrapping MAX<->0.
// Ports: clk, reset (async high), load/load_val, up, down, q.
module wrap_updown_counter #(
  parameter int MAX = 23,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // up and down together cancel out
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (up && !down) begin
      q_d = (q_q == W'(MAX)) ? '0 : q_q + 1'b1;
    end else if (down && !up) begin
      q_d = (q_q == '0) ? W'(MAX) : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/watch_time_set_controller.sv
// Time-set sequencer: enter edit, adjust hour, adjust minute, commit.
// Ports: clk, reset (async high), i_tick_1hz, btn_set/up/down,
//   i_cur_hour/min in; o_load, o_load_hour/min, o_editing,
//   o_disp_value, o_blank_mask out.
// Optional macro WATCH_SET_BLINK_EN adds a blink phase for o_blank_mask.
module watch_time_set_controller
  import watch_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int HOUR_MAX  = 23,
  parameter int MIN_MAX   = 59,
  parameter int DISP_W    = watch_pkg::DISP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick_1hz,
  input  logic              btn_set,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [4:0]        i_cur_hour,
  input  logic [5:0]        i_cur_min,
  output logic              o_load,
  output logic [4:0]        o_load_hour,
  output logic [5:0]        o_load_min,
  output logic              o_editing,
  output logic [DISP_W-1:0] o_disp_value,
  output logic [1:0]        o_blank_mask
);

  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  state_t state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic load_q, load_d;
  logic [4:0] load_hour_q, load_hour_d;
  logic [5:0] load_min_q, load_min_d;
  logic editing_q, editing_d;

  logic [4:0] edit_hour;
  logic [5:0] edit_min;

  logic in_edit, any_btn, adj_up, adj_dn, timeout_hit;

  assign in_edit = (state_q == SET_HOUR) || (state_q == SET_MIN);
  assign any_btn = btn_set | btn_up | btn_down;
  // set has priority over adjust; up+down cancel
  assign adj_up = btn_up & ~btn_down & ~btn_set;
  assign adj_dn = btn_down & ~btn_up & ~btn_set;
  // a button in the final-tick cycle keeps the edit alive
  assign timeout_hit = in_edit & i_tick_1hz & ~any_btn &
                       (to_q == TO_W'(TIMEOUT_S - 1));

  wrap_updown_counter #(.MAX(HOUR_MAX), .W(5)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q == IDLE) & btn_set),
    .load_val (i_cur_hour),
    .up       ((state_q == SET_HOUR) & adj_up),
    .down     ((state_q == SET_HOUR) & adj_dn),
    .q        (edit_hour)
  );

  wrap_updown_counter #(.MAX(MIN_MAX), .W(6)) u_min (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q == IDLE) & btn_set),
    .load_val (i_cur_min),
    .up       ((state_q == SET_MIN) & adj_up),
    .down     ((state_q == SET_MIN) & adj_dn),
    .q        (edit_min)
  );

  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    load_hour_d = load_hour_q;
    load_min_d  = load_min_q;
    unique case (state_q)
      IDLE: begin
        if (btn_set) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (btn_set)          state_d = SET_MIN;
        else if (timeout_hit) state_d = IDLE;
      end
      SET_MIN: begin
        if (btn_set) begin
          state_d     = COMMIT;
          load_d      = 1'b1;
          load_hour_d = edit_hour;
          load_min_d  = edit_min;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    to_d = to_q;
    if (!in_edit || any_btn) to_d = '0;
    else if (i_tick_1hz)     to_d = to_q + 1'b1;

    editing_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      to_q        <= '0;
      load_q      <= 1'b0;
      load_hour_q <= '0;
      load_min_q  <= '0;
      editing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_q        <= to_d;
      load_q      <= load_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      editing_q   <= editing_d;
    end
  end

  assign o_load      = load_q;
  assign o_load_hour = load_hour_q;
  assign o_load_min  = load_min_q;
  assign o_editing   = editing_q;

  assign o_disp_value = (state_q == IDLE)
    ? DISP_W'(disp_word(i_cur_hour, i_cur_min))
    : DISP_W'(disp_word(edit_hour, edit_min));

`ifdef WATCH_SET_BLINK_EN
  logic phase_q, phase_d;
  logic next_edit;

  assign next_edit = (state_d == SET_HOUR) || (state_d == SET_MIN);

  always_comb begin
    phase_d = phase_q;
    if (!next_edit || any_btn) phase_d = 1'b0;
    else if (i_tick_1hz)       phase_d = ~phase_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= 1'b0;
    else       phase_q <= phase_d;
  end

  assign o_blank_mask = {phase_q & (state_q == SET_HOUR),
                         phase_q & (state_q == SET_MIN)};
`else
  assign o_blank_mask = 2'b00;
`endif

endmodule

// File: tb/tb_watch_time_set_controller.sv
// Directed + randomized bench for watch_time_set_controller
// against a mode/field reference model.
module tb_watch_time_set_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_tick_1hz = 1'b0;
  logic        btn_set = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [4:0]  i_cur_hour = 5'd12;
  logic [5:0]  i_cur_min = 6'd34;
  logic        o_load;
  logic [4:0]  o_load_hour;
  logic [5:0]  o_load_min;
  logic        o_editing;
  logic [13:0] o_disp_value;
  logic [1:0]  o_blank_mask;

  int checks = 0;
  int failures = 0;

  // reference model: 0 idle, 1 hour, 2 minute, 3 commit
  int m_mode = 0;
  int m_eh = 0, m_em = 0, m_lh = 0, m_lm = 0, m_idle = 0;
  bit m_phase = 0, m_load = 0;

  always #5 clk = ~clk;

  watch_time_set_controller dut (
    .clk          (clk),
    .reset        (reset),
    .i_tick_1hz   (i_tick_1hz),
    .btn_set      (btn_set),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .i_cur_hour   (i_cur_hour),
    .i_cur_min    (i_cur_min),
    .o_load       (o_load),
    .o_load_hour  (o_load_hour),
    .o_load_min   (o_load_min),
    .o_editing    (o_editing),
    .o_disp_value (o_disp_value),
    .o_blank_mask (o_blank_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_eh = 0; m_em = 0; m_lh = 0; m_lm = 0;
    m_idle = 0; m_phase = 0; m_load = 0;
  endtask

  task automatic model_step(input bit s, u, d, t);
    m_load = 0;
    if (m_mode == 0) begin
      if (s) begin
        m_eh = int'(i_cur_hour); m_em = int'(i_cur_min);
        m_mode = 1; m_idle = 0; m_phase = 0;
      end
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (s || u || d) begin
      m_idle = 0; m_phase = 0;
      if (s) begin
        if (m_mode == 1) m_mode = 2;
        else begin
          m_mode = 3; m_lh = m_eh; m_lm = m_em; m_load = 1;
        end
      end else if (u != d) begin
        if (m_mode == 1) m_eh = u ? (m_eh + 1) % 24 : (m_eh + 23) % 24;
        else             m_em = u ? (m_em + 1) % 60 : (m_em + 59) % 60;
      end
    end else if (t) begin
      m_idle++;
      m_phase = !m_phase;
      if (m_idle >= 10) begin
        m_mode = 0; m_phase = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int disp;
    logic [1:0] mask;
    disp = (m_mode != 0) ? m_eh * 100 + m_em
                         : int'(i_cur_hour) * 100 + int'(i_cur_min);
`ifdef WATCH_SET_BLINK_EN
    mask = {m_phase && m_mode == 1, m_phase && m_mode == 2};
`else
    mask = 2'b00;
`endif
    chk({tag, ".load"}, 32'(o_load), 32'(m_load));
    chk({tag, ".load_hour"}, 32'(o_load_hour), 32'(m_lh));
    chk({tag, ".load_min"}, 32'(o_load_min), 32'(m_lm));
    chk({tag, ".editing"}, 32'(o_editing), 32'(m_mode != 0));
    chk({tag, ".disp"}, 32'(o_disp_value), 32'(disp));
    chk({tag, ".mask"}, 32'(o_blank_mask), 32'(mask));
  endtask

  task automatic step(input string tag, input bit s, u, d, t);
    @(negedge clk);
    btn_set = s; btn_up = u; btn_down = d; i_tick_1hz = t;
    @(posedge clk);
    #1;
    model_step(s, u, d, t);
    check_all(tag);
    btn_set = 0; btn_up = 0; btn_down = 0; i_tick_1hz = 0;
  endtask

  task automatic set_cur(input int h, input int m);
    i_cur_hour = 5'(h);
    i_cur_min = 6'(m);
  endtask

  initial begin
    bit s, u, d, t;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 0;

    // 1: basic edit and commit
    step("t1.idle", 0, 0, 0, 0);
    step("t1.enter", 1, 0, 0, 0);
    repeat (3) step("t1.up", 0, 1, 0, 0);
    step("t1.tomin", 1, 0, 0, 0);
    repeat (2) step("t1.dn", 0, 0, 1, 0);
    chk("t1.disp1532", 32'(o_disp_value), 32'd1532);
    step("t1.commit", 1, 0, 0, 0);
    chk("t1.loadstrobe", 32'(o_load), 32'd1);
    chk("t1.hour15", 32'(o_load_hour), 32'd15);
    chk("t1.min32", 32'(o_load_min), 32'd32);
    step("t1.after", 0, 0, 0, 0);
    chk("t1.loadlow", 32'(o_load), 32'd0);

    // 2: wrap up from 23:59, wrap down from 00:00
    set_cur(23, 59);
    step("t2.enter", 1, 0, 0, 0);
    step("t2.up", 0, 1, 0, 0);
    step("t2.tomin", 1, 0, 0, 0);
    step("t2.up", 0, 1, 0, 0);
    step("t2.commit", 1, 0, 0, 0);
    chk("t2.wrapup", 32'({o_load, o_load_hour, o_load_min}),
        32'({1'b1, 5'd0, 6'd0}));
    step("t2.gap", 0, 0, 0, 0);
    set_cur(0, 0);
    step("t2.enter2", 1, 0, 0, 0);
    step("t2.dn", 0, 0, 1, 0);
    step("t2.tomin2", 1, 0, 0, 0);
    step("t2.dn", 0, 0, 1, 0);
    step("t2.commit2", 1, 0, 0, 0);
    chk("t2.wrapdn", 32'({o_load, o_load_hour, o_load_min}),
        32'({1'b1, 5'd23, 6'd59}));
    step("t2.gap2", 0, 0, 0, 0);

    // 3: timeout in SET_MIN, then button on the final tick
    set_cur(8, 15);
    step("t3.enter", 1, 0, 0, 0);
    step("t3.tomin", 1, 0, 0, 0);
    repeat (9) step("t3.tick", 0, 0, 0, 1);
    chk("t3.stillediting", 32'(o_editing), 32'd1);
    step("t3.tick10", 0, 0, 0, 1);
    chk("t3.aborted", 32'(o_editing), 32'd0);
    chk("t3.noload", 32'(o_load), 32'd0);
    step("t3.enter2", 1, 0, 0, 0);
    step("t3.tomin2", 1, 0, 0, 0);
    repeat (9) step("t3.tick", 0, 0, 0, 1);
    step("t3.uptick10", 0, 1, 0, 1);
    chk("t3.kept", 32'(o_editing), 32'd1);
    chk("t3.disp", 32'(o_disp_value), 32'd816);
    repeat (9) step("t3.tick2", 0, 0, 0, 1);
    chk("t3.kept2", 32'(o_editing), 32'd1);
    step("t3.commit", 1, 0, 0, 0);
    step("t3.gap", 0, 0, 0, 0);

    // 4: simultaneous buttons
    set_cur(5, 40);
    step("t4.enter", 1, 0, 0, 0);
    step("t4.updn", 0, 1, 1, 0);
    chk("t4.hourkept", 32'(o_disp_value), 32'd540);
    step("t4.setup", 1, 1, 0, 0);
    chk("t4.setwins", 32'(o_disp_value), 32'd540);
    step("t4.up", 0, 1, 0, 0);
    chk("t4.minadj", 32'(o_disp_value), 32'd541);
    step("t4.commit", 1, 0, 0, 0);
    step("t4.gap", 0, 0, 0, 0);

    // 5: asynchronous reset mid-edit
    set_cur(3, 3);
    step("t5.enter", 1, 0, 0, 0);
    step("t5.tomin", 1, 0, 0, 0);
    step("t5.up", 0, 1, 0, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    model_reset();
    check_all("t5.inreset");
    @(negedge clk);
    reset = 0;
    repeat (3) step("t5.post", 0, 0, 0, 0);

    // 6: blink mask
    set_cur(10, 10);
    step("t6.enter", 1, 0, 0, 0);
    step("t6.tick", 0, 0, 0, 1);
`ifdef WATCH_SET_BLINK_EN
    chk("t6.blank", 32'(o_blank_mask), 32'd2);
`else
    chk("t6.blank", 32'(o_blank_mask), 32'd0);
`endif
    step("t6.up", 0, 1, 0, 0);
    chk("t6.unblank", 32'(o_blank_mask), 32'd0);
    step("t6.tomin", 1, 0, 0, 0);
    step("t6.commit", 1, 0, 0, 0);
    step("t6.gap", 0, 0, 0, 0);

    // random: busy buttons
    for (int i = 0; i < 1500; i++) begin
      if (m_mode == 0 && $urandom_range(0, 7) == 0)
        set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      s = ($urandom_range(0, 7) == 0);
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 2) == 0);
      step("rnd.busy", s, u, d, t);
    end

    // random: sparse buttons so timeouts occur
    for (int i = 0; i < 1500; i++) begin
      if (m_mode == 0 && $urandom_range(0, 7) == 0)
        set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      s = ($urandom_range(0, 29) == 0);
      u = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 1) == 0);
      step("rnd.sparse", s, u, d, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
